tartaruga_regfile: RTL and testbench

TARTARUGA_REGFILE -- requirements
Module: tartaruga_regfile

---
 rtl/tartaruga_pkg.sv | 19 +
 rtl/tartaruga_sb_counter.sv | 43 ++++
 rtl/tartaruga_regfile.sv | 115 +++++++++++
 tb/tb_tartaruga_regfile.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/tartaruga_pkg.sv
// tartaruga_pkg: shared constants and types for the tartaruga register file.
//   REG_COUNT     number of architectural registers (x0 is hardwired to zero)
//   MAX_INFLIGHT  pending writes that can be tracked per register
//   reg_addr_t    architectural register address
//   rf_rd_port_t  one read port request: address plus "operand is really used"
package tartaruga_pkg;

    localparam int REG_COUNT    = 32;
    localparam int MAX_INFLIGHT = 4;
    localparam int REG_AW       = $clog2(REG_COUNT);

    typedef logic [REG_AW-1:0] reg_addr_t;

    typedef struct packed {
        reg_addr_t addr;
        logic      rd_use;
    } rf_rd_port_t;

endpackage : tartaruga_pkg

// File: rtl/tartaruga_sb_counter.sv
// tartaruga_sb_counter: pending-write counter for one register.
//   clk_i, rstn_i  clock, asynchronous active-low reset
//   inc_i          an instruction writing this register issued
//   dec_i          a writeback to this register arrived
//   clear_i        flush; wins over inc/dec
//   cnt_o          current pending count, 0..MAX_INFLIGHT
//   full_o         cnt_o == MAX_INFLIGHT
//   busy_o         cnt_o != 0
module tartaruga_sb_counter #(
    parameter  int MAX_INFLIGHT = tartaruga_pkg::MAX_INFLIGHT,
    localparam int CW           = $clog2(MAX_INFLIGHT + 1)
) (
    input  logic          clk_i,
    input  logic          rstn_i,
    input  logic          inc_i,
    input  logic          dec_i,
    input  logic          clear_i,
    output logic [CW-1:0] cnt_o,
    output logic          full_o,
    output logic          busy_o
);
    import tartaruga_pkg::*;

    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            cnt_q <= '0;
        end else if (clear_i) begin
            cnt_q <= '0;
        end else if (inc_i && !dec_i) begin
            if (cnt_q != CW'(MAX_INFLIGHT)) cnt_q <= cnt_q + CW'(1);
        end else if (dec_i && !inc_i) begin
            // A writeback with nothing pending (e.g. after a flush) must not wrap.
            if (cnt_q != '0) cnt_q <= cnt_q - CW'(1);
        end
    end

    assign cnt_o  = cnt_q;
    assign full_o = (cnt_q == CW'(MAX_INFLIGHT));
    assign busy_o = (cnt_q != '0);

endmodule : tartaruga_sb_counter

// File: rtl/tartaruga_regfile.sv
// tartaruga_regfile: register file with per-register pending-write scoreboard.
//   clk_i, rstn_i        clock, asynchronous active-low reset
//   rd_addr_i/rd_use_i   NUM_RD combinational read ports and "operand used" flags
//   rd_data_o/rd_busy_o  read data (optionally forwarded from writeback), pending flag
//   issue_*              decode offers an instruction and its destination
//   wb_*                 writeback of one register per cycle
//   flush_i              drop all pending-write tracking
// Handshake: an instruction issues on a rising edge where issue_valid_i and
// issue_ready_o are both 1. issue_ready_o never looks at issue_valid_i, so
// decode may use it to decide whether to raise valid.
// Note: read-port addresses travel through rf_rd_port_t, whose address is
// reg_addr_t; REG_COUNT must not exceed tartaruga_pkg::REG_COUNT.
module tartaruga_regfile #(
    parameter  int XLEN         = 32,
    parameter  int REG_COUNT    = tartaruga_pkg::REG_COUNT,
    parameter  int NUM_RD       = 2,
    parameter  int MAX_INFLIGHT = tartaruga_pkg::MAX_INFLIGHT,
    parameter  int BYPASS       = 1,
    localparam int AW           = $clog2(REG_COUNT),
    localparam int CW           = $clog2(MAX_INFLIGHT + 1)
) (
    input  logic                       clk_i,
    input  logic                       rstn_i,
    input  logic [NUM_RD-1:0][AW-1:0]  rd_addr_i,
    input  logic [NUM_RD-1:0]          rd_use_i,
    output logic [NUM_RD-1:0][XLEN-1:0] rd_data_o,
    output logic [NUM_RD-1:0]          rd_busy_o,
    input  logic                       issue_valid_i,
    input  logic                       issue_we_i,
    input  logic [AW-1:0]              issue_rd_i,
    output logic                       issue_ready_o,
    input  logic                       wb_valid_i,
    input  logic [AW-1:0]              wb_addr_i,
    input  logic [XLEN-1:0]            wb_data_i,
    input  logic                       flush_i
);
    import tartaruga_pkg::*;

    logic [XLEN-1:0]      regs [REG_COUNT];
    logic [CW-1:0]        cnt  [REG_COUNT];
    logic [REG_COUNT-1:0] full_vec;
    logic [REG_COUNT-1:0] busy_vec;
    rf_rd_port_t          rd_port [NUM_RD];
    logic                 issue_fire;
    logic                 wb_live;

    assign wb_live    = wb_valid_i && (wb_addr_i != '0);
    assign issue_fire = issue_valid_i && issue_ready_o;

    // regs[0] is reset and never written, so it always holds zero.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            for (int i = 0; i < REG_COUNT; i++) regs[i] <= '0;
        end else if (wb_live) begin
            regs[wb_addr_i] <= wb_data_i;
        end
    end

    // x0 never tracks anything.
    assign cnt[0]      = '0;
    assign full_vec[0] = 1'b0;
    assign busy_vec[0] = 1'b0;

    for (genvar r = 1; r < REG_COUNT; r++) begin : g_sb
        tartaruga_sb_counter #(
            .MAX_INFLIGHT (MAX_INFLIGHT)
        ) u_cnt (
            .clk_i   (clk_i),
            .rstn_i  (rstn_i),
            .inc_i   (issue_fire && issue_we_i && (issue_rd_i == AW'(r))),
            .dec_i   (wb_valid_i && (wb_addr_i == AW'(r))),
            .clear_i (flush_i),
            .cnt_o   (cnt[r]),
            .full_o  (full_vec[r]),
            .busy_o  (busy_vec[r])
        );
    end

    always_comb begin
        for (int p = 0; p < NUM_RD; p++) begin
            rd_port[p].addr   = reg_addr_t'(rd_addr_i[p]);
            rd_port[p].rd_use = rd_use_i[p];
        end
    end

    logic            src_stall;
    logic            dst_full;
    logic [AW-1:0]   a;
    logic            hit;

    always_comb begin
        src_stall = 1'b0;
        a         = '0;
        hit       = 1'b0;
        rd_data_o = '0;
        rd_busy_o = '0;
        for (int p = 0; p < NUM_RD; p++) begin
            a   = AW'(rd_port[p].addr);
            hit = (BYPASS != 0) && wb_live && (wb_addr_i == a);
            if (a != '0) begin
                rd_data_o[p] = hit ? wb_data_i : regs[a];
                // The last outstanding write resolves this cycle when forwarded.
                rd_busy_o[p] = busy_vec[a] && ((cnt[a] != CW'(1)) || !hit);
            end
            if (rd_port[p].rd_use && rd_busy_o[p]) src_stall = 1'b1;
        end
    end

    // A same-cycle writeback to a full destination frees the slot the issue takes.
    assign dst_full = issue_we_i && full_vec[issue_rd_i] &&
                      !(wb_valid_i && (wb_addr_i == issue_rd_i));

    assign issue_ready_o = !(src_stall || dst_full);

endmodule : tartaruga_regfile

// File: tb/tb_tartaruga_regfile.sv
module tb_tartaruga_regfile;

    logic             clk;
    logic             rstn;
    logic [1:0][4:0]  rd_addr;
    logic [1:0]       rd_use;
    logic [1:0][31:0] rd_data, rd_data_nb;
    logic [1:0]       rd_busy, rd_busy_nb;
    logic             issue_valid, issue_we;
    logic [4:0]       issue_rd;
    logic             ready, ready_nb;
    logic             wb_valid;
    logic [4:0]       wb_addr;
    logic [31:0]      wb_data;
    logic             flush;

    int n_checks = 0;
    int n_fail   = 0;

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    tartaruga_regfile #(.BYPASS(1)) dut (
        .clk_i(clk), .rstn_i(rstn),
        .rd_addr_i(rd_addr), .rd_use_i(rd_use),
        .rd_data_o(rd_data), .rd_busy_o(rd_busy),
        .issue_valid_i(issue_valid), .issue_we_i(issue_we), .issue_rd_i(issue_rd),
        .issue_ready_o(ready),
        .wb_valid_i(wb_valid), .wb_addr_i(wb_addr), .wb_data_i(wb_data),
        .flush_i(flush)
    );

    tartaruga_regfile #(.BYPASS(0)) dut_nb (
        .clk_i(clk), .rstn_i(rstn),
        .rd_addr_i(rd_addr), .rd_use_i(rd_use),
        .rd_data_o(rd_data_nb), .rd_busy_o(rd_busy_nb),
        .issue_valid_i(issue_valid), .issue_we_i(issue_we), .issue_rd_i(issue_rd),
        .issue_ready_o(ready_nb),
        .wb_valid_i(wb_valid), .wb_addr_i(wb_addr), .wb_data_i(wb_data),
        .flush_i(flush)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // advance to just after the next rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_wb(input logic v, input logic [4:0] addr, input logic [31:0] data);
        wb_valid = v;
        wb_addr  = addr;
        wb_data  = data;
    endtask

    task automatic drive_issue(input logic v, input logic we, input logic [4:0] rd);
        issue_valid = v;
        issue_we    = we;
        issue_rd    = rd;
    endtask

    initial begin
        rstn = 1'b0;
        rd_addr = '0; rd_use = '0;
        drive_issue(0, 0, 0);
        drive_wb(0, 0, 0);
        flush = 1'b0;
        step(); step();
        #1;
        check("rst_data0", rd_data[0], 32'h0);
        check("rst_busy", {30'd0, rd_busy}, 32'h0);
        check("rst_ready", {31'd0, ready}, 32'h1);
        step();
        rstn = 1'b1;

        // write x5 and read it
        rd_addr[0] = 5'd5;
        drive_wb(1, 5'd5, 32'hDEADBEEF);
        #1;
        check("x5_fwd", rd_data[0], 32'hDEADBEEF);
        check("x5_nofwd_old", rd_data_nb[0], 32'h0);
        step();
        drive_wb(0, 0, 0);
        #1;
        check("x5_stored", rd_data[0], 32'hDEADBEEF);
        check("x5_stored_nb", rd_data_nb[0], 32'hDEADBEEF);

        // x0 is inert
        rd_addr[0] = 5'd0; rd_use = 2'b01;
        drive_issue(1, 1, 5'd0);
        drive_wb(1, 5'd0, 32'h1234);
        #1;
        check("x0_fwd", rd_data[0], 32'h0);
        check("x0_ready", {31'd0, ready}, 32'h1);
        step();
        drive_issue(0, 0, 0);
        drive_wb(0, 0, 0);
        #1;
        check("x0_read", rd_data[0], 32'h0);
        check("x0_busy", {31'd0, rd_busy[0]}, 32'h0);
        check("x0_ready_after", {31'd0, ready}, 32'h1);

        // fill x7 to MAX_INFLIGHT
        rd_use = 2'b00;
        drive_issue(1, 1, 5'd7);
        for (int i = 0; i < 4; i++) begin
            #1;
            check("x7_fill_ready", {31'd0, ready}, 32'h1);
            step();
        end
        #1;
        check("x7_full_stall", {31'd0, ready}, 32'h0);
        drive_wb(1, 5'd7, 32'h70);
        #1;
        check("x7_full_wb_ready", {31'd0, ready}, 32'h1);
        step();
        drive_wb(0, 0, 0);
        #1;
        check("x7_cnt_stays_full", {31'd0, ready}, 32'h0);
        drive_issue(0, 0, 0);
        rd_addr[1] = 5'd7;
        #1;
        check("x7_busy_full", {31'd0, rd_busy[1]}, 32'h1);
        for (int i = 0; i < 4; i++) begin
            drive_wb(1, 5'd7, 32'h71 + i);
            step();
        end
        drive_wb(0, 0, 0);
        #1;
        check("x7_drained_busy", {31'd0, rd_busy[1]}, 32'h0);
        check("x7_last_data", rd_data[1], 32'h74);
        drive_wb(1, 5'd7, 32'h99);
        step();
        drive_wb(0, 0, 0);
        #1;
        check("x7_no_underflow", {31'd0, rd_busy[1]}, 32'h0);
        check("x7_wb_at_zero", rd_data[1], 32'h99);

        // RAW hazard on x3
        drive_issue(1, 1, 5'd3);
        step();
        drive_issue(0, 0, 0);
        rd_addr[0] = 5'd3; rd_use = 2'b01;
        #1;
        check("x3_busy", {31'd0, rd_busy[0]}, 32'h1);
        check("x3_stall", {31'd0, ready}, 32'h0);
        check("x3_busy_nb", {31'd0, rd_busy_nb[0]}, 32'h1);
        drive_wb(1, 5'd3, 32'hABC);
        #1;
        check("x3_wb_busy", {31'd0, rd_busy[0]}, 32'h0);
        check("x3_wb_ready", {31'd0, ready}, 32'h1);
        check("x3_wb_data", rd_data[0], 32'hABC);
        check("x3_wb_busy_nb", {31'd0, rd_busy_nb[0]}, 32'h1);
        check("x3_wb_ready_nb", {31'd0, ready_nb}, 32'h0);
        check("x3_wb_data_nb", rd_data_nb[0], 32'h0);
        step();
        drive_wb(0, 0, 0);
        #1;
        check("x3_after_busy", {31'd0, rd_busy[0]}, 32'h0);
        check("x3_after_busy_nb", {31'd0, rd_busy_nb[0]}, 32'h0);

        // flush overrides a same-cycle issue on x9
        rd_use = 2'b00;
        drive_issue(1, 1, 5'd9);
        step(); step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        drive_issue(0, 0, 0);
        rd_addr[0] = 5'd9; rd_use = 2'b01;
        #1;
        check("x9_flush_busy", {31'd0, rd_busy[0]}, 32'h0);
        check("x9_flush_ready", {31'd0, ready}, 32'h1);
        drive_wb(1, 5'd9, 32'h55);
        step();
        drive_wb(0, 0, 0);
        #1;
        check("x9_late_wb_data", rd_data[0], 32'h55);
        check("x9_late_wb_busy", {31'd0, rd_busy[0]}, 32'h0);

        // asynchronous reset with x2 pending twice
        rd_use = 2'b00;
        drive_wb(1, 5'd2, 32'h22);
        step();
        drive_wb(0, 0, 0);
        drive_issue(1, 1, 5'd2);
        step(); step();
        drive_issue(0, 0, 0);
        rd_addr[0] = 5'd2; rd_use = 2'b01;
        #1;
        check("x2_busy_pre", {31'd0, rd_busy[0]}, 32'h1);
        check("x2_data_pre", rd_data[0], 32'h22);
        check("x2_ready_pre", {31'd0, ready}, 32'h0);
        #2;
        rstn = 1'b0;
        #1;
        check("x2_rst_busy", {31'd0, rd_busy[0]}, 32'h0);
        check("x2_rst_data", rd_data[0], 32'h0);
        check("x2_rst_ready", {31'd0, ready}, 32'h1);
        step();
        rstn = 1'b1;
        rd_use = 2'b00;
        drive_issue(1, 1, 5'd2);
        step();
        drive_issue(0, 0, 0);
        rd_use = 2'b01;
        #1;
        check("x2_clean_busy", {31'd0, rd_busy[0]}, 32'h1);
        drive_wb(1, 5'd2, 32'h33);
        #1;
        check("x2_clean_resolve", {31'd0, rd_busy[0]}, 32'h0);
        step();
        drive_wb(0, 0, 0);
        #1;
        check("x2_clean_data", rd_data[0], 32'h33);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #50000;
        n_fail++;
        $display("FAIL watchdog observed=timeout expected=completion");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_tartaruga_regfile
